mac_array_ctrl: RTL
===================

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIM, default 64: maximum feature-map height/width.
REQ-002 SHALL have parameter MAX_GRP, default 16: maximum input/output channel groups.
REQ-003 SHALL have parameter PIPE_LAT, default 6: MAC array data latency in pipe_en cycles.
REQ-004 SHALL have ports: clk  in  1  clock. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: conv_start  in  1  start pulse, sampled in IDLE only.
REQ-007 SHALL have ports: conv_abort  in  1  abort the run.
REQ-008 SHALL have ports: cfg_h, cfg_w  in  clog2(MAX_DIM+1)  fmap height/width.
REQ-009 SHALL have ports: cfg_in_grp, cfg_out_grp  in  clog2(MAX_GRP+1)  group counts.
REQ-010 SHALL have ports: mac_array2psum_acc_rdy  in  1  downstream ready.
REQ-011 SHALL have ports: mac_array2psum_acc_vld  out  1  output data valid.
REQ-012 SHALL have ports: mac_array2psum_acc_info  out  32  {zero-pad, out_grp, in_grp, pixel offset}.
REQ-013 SHALL have ports: pipe_en  out  1  global array stall.
REQ-014 SHALL have ports: pe_en  out  10  PE mask (bit 9 identity, bits 8:0 3x3 window).
REQ-015 SHALL have ports: imap_ren  out  1.
REQ-016 SHALL have ports: imap_raddr  out  32  {in_grp, pixel index}.
REQ-017 SHALL have ports: in_grp_cnt, out_grp_cnt  out  clog2(MAX_GRP).
REQ-018 SHALL have ports: busy  out  1; conv_done  out  1; cfg_err  out  1.

Function
REQ-019 SHALL latch cfg_* on an accepted conv_start; cfg changes afterward have no effect until the next start.
REQ-020 SHALL reject cfg_h or cfg_w outside 3..MAX_DIM, or a group count of 0 or above MAX_GRP: pulse cfg_err for 1 cycle and stay IDLE.
REQ-021 SHALL implement the states IDLE, SETUP, CONV and COOL.
REQ-022 SHALL go IDLE->SETUP on a valid start.
REQ-023 SHALL go SETUP->CONV when setup_cnt==cfg_w+1 and pipe_en is high.
REQ-024 SHALL go CONV->COOL at row==H-1, col==W-1, in_grp==last, out_grp==last, with pipe_en high.
REQ-025 SHALL go COOL->IDLE when the final output beat is accepted.
REQ-026 SHALL drive pipe_en = (state!=IDLE) && mac_array2psum_acc_rdy; every counter and state advance is gated by pipe_en.
REQ-027 SHALL, in CONV, advance col on each pipe_en and wrap it at W-1.
REQ-028 SHALL increment row on col wrap and wrap it at H-1.
REQ-029 SHALL increment in_grp on a plane wrap and wrap it at cfg_in_grp-1.
REQ-030 SHALL increment out_grp on an in_grp wrap.
REQ-031 SHALL set pe_en=0 outside CONV; in CONV, bit 9=1, with bits 8:6 cleared on row 0, bits 2:0 cleared on row H-1, bits {8,5,2} cleared on col 0, and bits {6,3,0} cleared on col W-1.
REQ-032 SHALL drive imap_ren = (SETUP||CONV) && pipe_en.
REQ-033 SHALL increment the read pixel index per imap_ren and wrap it at H*W-1; imap_raddr upper field = current read group.
REQ-034 SHALL assert mac_array2psum_acc_vld exactly PIPE_LAT pipe_en-cycles after the CONV cycle that produced it; the delay line holds while pipe_en is low.
REQ-035 SHALL advance the output pixel offset on each vld&&rdy, wrapping at H*W-1.
REQ-036 SHALL advance the output plane counter on offset wrap; mac_array2psum_acc_info reflects the beat being presented.
REQ-037 SHALL pulse conv_done for exactly 1 cycle on COOL->IDLE.
REQ-038 SHALL hold busy=1 in all states except IDLE.
REQ-039 SHALL, on conv_abort in any non-IDLE state, go to IDLE on the next edge, clearing all counters and the vld delay line, without conv_done; abort takes priority over every other transition.
REQ-040 SHALL ignore conv_start while busy.
REQ-041 SHALL make no progress while rdy stays low; no beat is lost or duplicated.

Reset
REQ-042 SHALL, with rst high at a clk edge, set state=IDLE; all counters, latched cfg and the vld delay line to 0; conv_done=cfg_err=busy=vld=0.
REQ-043 SHALL give reset priority over conv_abort and conv_start, including mid-run.

Structure
REQ-044 SHALL place the state encoding, the PE mask bit-position constants and the info field widths in the shared package mac_ctrl_pkg.
REQ-045 SHALL implement the PIPE_LAT-deep pipe_en-gated valid delay as sub-module mac_vld_pipe.

Verification
REQ-046 SHALL cover: H=W=4, 1 in/1 out group, rdy=1 -> SETUP 6 cycles, CONV 16 cycles, 16 vld beats with offsets 0..15, conv_done 1 cycle after beat 15.
REQ-047 SHALL cover: H=W=4, corner cycles (0,0),(0,3),(3,0),(3,3) -> pe_en = 10'b1000011011, 1000110110, 1011011000, 1110110000; centre (1,1) -> 10'b1111111111.
REQ-048 SHALL cover: H=W=5, 2 in/2 out groups, rdy randomly low 30% -> exactly 100 beats, info group fields sequence 00,01,10,11, no gaps.
REQ-049 SHALL cover: conv_abort at CONV cycle 7 -> IDLE next cycle, vld=0, conv_done never asserted; then a new start runs normally.
REQ-050 SHALL cover: cfg_w=2, then cfg_out_grp=0 -> each gives a cfg_err 1-cycle pulse, busy stays 0.
REQ-051 SHALL cover: rst pulsed mid-CONV -> all outputs 0 next cycle; conv_start while busy -> ignored.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared encodings for the MAC array controller -- FSM states,
// PE window bit positions and the output tag / read address field layout.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_CONV  = 2'd2,
    ST_COOL  = 2'd3
  } ctrl_state_e;

  localparam int PE_W  = 10;
  localparam int PE_ID = 9;
  localparam int PE_TL = 8;
  localparam int PE_T  = 7;
  localparam int PE_TR = 6;
  localparam int PE_L  = 5;
  localparam int PE_C  = 4;
  localparam int PE_R  = 3;
  localparam int PE_BL = 2;
  localparam int PE_B  = 1;
  localparam int PE_BR = 0;

  localparam int INFO_OFF_W  = 16;
  localparam int INFO_GRP_W  = 6;
  localparam int INFO_PAD_W  = 32 - INFO_OFF_W - 2 * INFO_GRP_W;
  localparam int RADDR_PAD_W = 32 - INFO_OFF_W - INFO_GRP_W;

  // 3x3 window mask with the taps that fall outside the feature map removed.
  function automatic logic [PE_W-1:0] pe_mask(input logic top, input logic bot,
                                               input logic lft, input logic rgt);
    logic [PE_W-1:0] m;
    m = {PE_W{1'b1}};
    if (top) begin
      m[PE_TL] = 1'b0; m[PE_T] = 1'b0; m[PE_TR] = 1'b0;
    end
    if (bot) begin
      m[PE_BL] = 1'b0; m[PE_B] = 1'b0; m[PE_BR] = 1'b0;
    end
    if (lft) begin
      m[PE_TL] = 1'b0; m[PE_L] = 1'b0; m[PE_BL] = 1'b0;
    end
    if (rgt) begin
      m[PE_TR] = 1'b0; m[PE_R] = 1'b0; m[PE_BR] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/mac_vld_pipe.sv
// mac_vld_pipe: LAT-deep valid delay line that only shifts on en, so a stalled
// array keeps every in-flight beat in place.
module mac_vld_pipe #(
  parameter int LAT = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] r_line;

  // Shift register advanced by the array enable, flushed by reset or abort.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_line <= {LAT{1'b0}};
    end else if (en) begin
      r_line[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        r_line[i] <= r_line[i-1];
      end
    end else begin
      r_line <= r_line;
    end
  end

  assign dout = r_line[LAT-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences a 3x3 convolution over a latched fmap/group config,
// driving PE enables, input-map reads and tagged output beats to the accumulator.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int MAX_DIM  = 64,
  parameter int MAX_GRP  = 16,
  parameter int PIPE_LAT = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         conv_start,
  input  logic                         conv_abort,
  input  logic [$clog2(MAX_DIM+1)-1:0] cfg_h,
  input  logic [$clog2(MAX_DIM+1)-1:0] cfg_w,
  input  logic [$clog2(MAX_GRP+1)-1:0] cfg_in_grp,
  input  logic [$clog2(MAX_GRP+1)-1:0] cfg_out_grp,
  input  logic                         mac_array2psum_acc_rdy,
  output logic                         mac_array2psum_acc_vld,
  output logic [31:0]                  mac_array2psum_acc_info,
  output logic                         pipe_en,
  output logic [PE_W-1:0]              pe_en,
  output logic                         imap_ren,
  output logic [31:0]                  imap_raddr,
  output logic [$clog2(MAX_GRP)-1:0]   in_grp_cnt,
  output logic [$clog2(MAX_GRP)-1:0]   out_grp_cnt,
  output logic                         busy,
  output logic                         conv_done,
  output logic                         cfg_err
);

  localparam int DW  = $clog2(MAX_DIM + 1);
  localparam int SW  = DW + 1;
  localparam int GW  = $clog2(MAX_GRP + 1);
  localparam int GCW = $clog2(MAX_GRP);
  localparam int PW  = 2 * DW;

  localparam logic [DW-1:0]  DIM_MIN = DW'(3);
  localparam logic [DW-1:0]  DIM_MAX = DW'(MAX_DIM);
  localparam logic [GW-1:0]  GRP_MAX = GW'(MAX_GRP);
  localparam logic [DW-1:0]  ONE_D   = DW'(1);
  localparam logic [SW-1:0]  ONE_S   = SW'(1);
  localparam logic [GW-1:0]  ONE_G   = GW'(1);
  localparam logic [GCW-1:0] ONE_C   = GCW'(1);
  localparam logic [PW-1:0]  ONE_P   = PW'(1);

  ctrl_state_e    r_state;
  logic [DW-1:0]  r_cfg_h, r_cfg_w;
  logic [GW-1:0]  r_cfg_in, r_cfg_out;
  logic [SW-1:0]  r_setup_cnt;
  logic [DW-1:0]  r_row, r_col;
  logic [GCW-1:0] r_in_grp, r_out_grp;
  logic [PW-1:0]  r_rd_pix, r_out_off;
  logic [GCW-1:0] r_rd_grp, r_out_in, r_out_out;
  logic           r_conv_done, r_cfg_err;

  logic           w_pipe_en, w_abort, w_cfg_ok, w_conv_act, w_vld, w_beat;
  logic [PW-1:0]  w_hw, w_plane_last;
  logic [SW-1:0]  w_setup_end;
  logic           w_col_last, w_row_last, w_in_last, w_out_last;
  logic           w_rd_pix_last, w_rd_grp_last, w_imap_ren;
  logic           w_off_last, w_oin_last, w_oout_last, w_final_beat, w_run_clr;

  assign w_pipe_en  = (r_state != ST_IDLE) && mac_array2psum_acc_rdy;
  assign w_abort    = (r_state != ST_IDLE) && conv_abort;
  assign w_conv_act = (r_state == ST_CONV);

  assign w_cfg_ok = (cfg_h >= DIM_MIN) && (cfg_h <= DIM_MAX) &&
                    (cfg_w >= DIM_MIN) && (cfg_w <= DIM_MAX) &&
                    (cfg_in_grp  != {GW{1'b0}}) && (cfg_in_grp  <= GRP_MAX) &&
                    (cfg_out_grp != {GW{1'b0}}) && (cfg_out_grp <= GRP_MAX);

  assign w_hw         = PW'(r_cfg_h) * PW'(r_cfg_w);
  assign w_plane_last = w_hw - ONE_P;
  assign w_setup_end  = {1'b0, r_cfg_w} + ONE_S;

  assign w_col_last = (r_col == r_cfg_w - ONE_D);
  assign w_row_last = (r_row == r_cfg_h - ONE_D);
  assign w_in_last  = (GW'(r_in_grp)  == r_cfg_in  - ONE_G);
  assign w_out_last = (GW'(r_out_grp) == r_cfg_out - ONE_G);

  assign w_imap_ren    = ((r_state == ST_SETUP) || (r_state == ST_CONV)) && w_pipe_en;
  assign w_rd_pix_last = (r_rd_pix == w_plane_last);
  assign w_rd_grp_last = (GW'(r_rd_grp) == r_cfg_in - ONE_G);

  // A beat only leaves when the accumulator takes it; the plane tag is {out, in}.
  assign w_beat       = w_vld && mac_array2psum_acc_rdy;
  assign w_off_last   = (r_out_off == w_plane_last);
  assign w_oin_last   = (GW'(r_out_in)  == r_cfg_in  - ONE_G);
  assign w_oout_last  = (GW'(r_out_out) == r_cfg_out - ONE_G);
  assign w_final_beat = w_beat && w_off_last && w_oin_last && w_oout_last;
  assign w_run_clr    = w_abort || ((r_state == ST_COOL) && w_final_beat);

  // Control FSM: config latch, setup/conv sequencing, completion and abort.
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_state     <= ST_IDLE;
      r_setup_cnt <= {SW{1'b0}};
      r_row       <= {DW{1'b0}};
      r_col       <= {DW{1'b0}};
      r_in_grp    <= {GCW{1'b0}};
      r_out_grp   <= {GCW{1'b0}};
      r_conv_done <= 1'b0;
      r_cfg_err   <= 1'b0;
      if (rst) begin
        r_cfg_h   <= {DW{1'b0}};
        r_cfg_w   <= {DW{1'b0}};
        r_cfg_in  <= {GW{1'b0}};
        r_cfg_out <= {GW{1'b0}};
      end else begin
        r_cfg_h   <= r_cfg_h;
        r_cfg_w   <= r_cfg_w;
        r_cfg_in  <= r_cfg_in;
        r_cfg_out <= r_cfg_out;
      end
    end else begin
      r_conv_done <= 1'b0;
      r_cfg_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (conv_start && w_cfg_ok) begin
            r_cfg_h   <= cfg_h;
            r_cfg_w   <= cfg_w;
            r_cfg_in  <= cfg_in_grp;
            r_cfg_out <= cfg_out_grp;
            r_state   <= ST_SETUP;
          end else if (conv_start) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (w_pipe_en) begin
            if (r_setup_cnt == w_setup_end) begin
              r_setup_cnt <= {SW{1'b0}};
              r_state     <= ST_CONV;
            end else begin
              r_setup_cnt <= r_setup_cnt + ONE_S;
            end
          end
        end
        ST_CONV: begin
          if (w_pipe_en) begin
            if (!w_col_last) begin
              r_col <= r_col + ONE_D;
            end else begin
              r_col <= {DW{1'b0}};
              if (!w_row_last) begin
                r_row <= r_row + ONE_D;
              end else begin
                r_row <= {DW{1'b0}};
                if (!w_in_last) begin
                  r_in_grp <= r_in_grp + ONE_C;
                end else begin
                  r_in_grp <= {GCW{1'b0}};
                  if (!w_out_last) begin
                    r_out_grp <= r_out_grp + ONE_C;
                  end else begin
                    r_out_grp <= {GCW{1'b0}};
                    r_state   <= ST_COOL;
                  end
                end
              end
            end
          end
        end
        ST_COOL: begin
          if (w_final_beat) begin
            r_state     <= ST_IDLE;
            r_conv_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Input-map read address and output beat tag counters.
  always_ff @(posedge clk) begin
    if (rst || w_run_clr) begin
      r_rd_pix  <= {PW{1'b0}};
      r_rd_grp  <= {GCW{1'b0}};
      r_out_off <= {PW{1'b0}};
      r_out_in  <= {GCW{1'b0}};
      r_out_out <= {GCW{1'b0}};
    end else begin
      if (w_imap_ren) begin
        if (w_rd_pix_last) begin
          r_rd_pix <= {PW{1'b0}};
          r_rd_grp <= w_rd_grp_last ? {GCW{1'b0}} : r_rd_grp + ONE_C;
        end else begin
          r_rd_pix <= r_rd_pix + ONE_P;
        end
      end
      if (w_beat) begin
        if (w_off_last) begin
          r_out_off <= {PW{1'b0}};
          if (w_oin_last) begin
            r_out_in  <= {GCW{1'b0}};
            r_out_out <= w_oout_last ? {GCW{1'b0}} : r_out_out + ONE_C;
          end else begin
            r_out_in <= r_out_in + ONE_C;
          end
        end else begin
          r_out_off <= r_out_off + ONE_P;
        end
      end
    end
  end

  mac_vld_pipe #(
    .LAT (PIPE_LAT)
  ) u_vld_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_abort),
    .en   (w_pipe_en),
    .din  (w_conv_act),
    .dout (w_vld)
  );

  assign pipe_en  = w_pipe_en;
  assign imap_ren = w_imap_ren;
  assign pe_en    = w_conv_act ? pe_mask(r_row == {DW{1'b0}}, w_row_last,
                                         r_col == {DW{1'b0}}, w_col_last)
                               : {PE_W{1'b0}};

  assign mac_array2psum_acc_vld  = w_vld;
  assign mac_array2psum_acc_info = {{INFO_PAD_W{1'b0}}, INFO_GRP_W'(r_out_out),
                                    INFO_GRP_W'(r_out_in), INFO_OFF_W'(r_out_off)};
  assign imap_raddr  = {{RADDR_PAD_W{1'b0}}, INFO_GRP_W'(r_rd_grp), INFO_OFF_W'(r_rd_pix)};
  assign in_grp_cnt  = r_in_grp;
  assign out_grp_cnt = r_out_grp;
  assign busy        = (r_state != ST_IDLE);
  assign conv_done   = r_conv_done;
  assign cfg_err     = r_cfg_err;

endmodule
